// File: rtl/state_mon_pkg.sv
// state_mon_pkg
// Shared definitions for the FSM state monitor blocks.
//   STATE_W       : width of the observed FSM state
//   DEFAULT_CNT_W : default run-count width of a run-length record
//   rle_rec_t     : one run-length record {state, count}
package state_mon_pkg;

  localparam int STATE_W       = 3;
  localparam int DEFAULT_CNT_W = 5;

  typedef struct packed {
    logic [STATE_W-1:0]       state;
    logic [DEFAULT_CNT_W-1:0] count;
  } rle_rec_t;

endpackage

// File: rtl/rle_fifo.sv
// rle_fifo
// Small register-array FIFO for run-length records. A push is accepted when
// there is room or when the head is popped in the same cycle; otherwise the
// record is dropped and a one-cycle drop pulse is raised. DEPTH must be a
// power of two (at least 2) so the pointers wrap naturally.
// Ports:
//   clk, reset (async, active-low)
//   push, push_data       : record offered this cycle
//   pop_ready             : consumer accepts the head record
//   out_valid, out_data   : head record, driven straight from registers
//   level                 : occupancy, 0..DEPTH
//   drop                  : pushed record was discarded this cycle
module rle_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             pop;
  logic             accept;

  // A pop frees the head slot in the same cycle, so a full FIFO can still
  // accept a record while it is being drained.
  assign pop    = (level_q != '0) & pop_ready;
  assign accept = push & ((level_q != FULL_LVL) | pop);
  assign drop   = push & ~accept;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (accept) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({accept, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage is cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;

endmodule

// File: rtl/state_rle_logger.sv
// state_rle_logger
// Observes the control FSM state every clock and compresses runs of equal
// states into (state, count) records, buffered in rle_fifo and drained over a
// valid/ready port. A dropped record sets a sticky overflow flag.
// Ports:
//   clk, reset (async, active-low)
//   s_in       : FSM state sampled each posedge
//   flush      : close the current run now
//   clear_ovf  : synchronous clear of overflow
//   out_valid / out_ready / out_state / out_count : record output
//   overflow   : sticky, a record was dropped
//   level      : FIFO occupancy
module state_rle_logger
  import state_mon_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STATE_W-1:0]     s_in,
  input  logic                   flush,
  input  logic                   clear_ovf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [STATE_W-1:0]     out_state,
  output logic [CNT_W-1:0]       out_count,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int               REC_W   = STATE_W + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [STATE_W-1:0] cur_state_q, cur_state_d;
  logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic               run_active_q, run_active_d;
  logic               overflow_q, overflow_d;
  logic               close_run;
  logic               drop;
  logic [REC_W-1:0]   head_rec;

  // A run closes on a state change, on saturation, or on request. The
  // sampled state always opens the next run, so a saturated run continues
  // seamlessly with count 1 in the closing cycle.
  assign close_run = run_active_q &
                     ((s_in != cur_state_q) | (run_cnt_q == CNT_MAX) | flush);

  // Run tracker next-state.
  always_comb begin
    cur_state_d  = cur_state_q;
    run_cnt_d    = run_cnt_q;
    run_active_d = run_active_q;
    if (!run_active_q) begin
      cur_state_d  = s_in;
      run_cnt_d    = CNT_W'(1);
      run_active_d = 1'b1;
    end else if (close_run) begin
      cur_state_d = s_in;
      run_cnt_d   = CNT_W'(1);
    end else begin
      run_cnt_d = run_cnt_q + 1'b1;
    end
  end

  // A drop in the same cycle as clear_ovf keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Run and overflow registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state_q  <= '0;
      run_cnt_q    <= '0;
      run_active_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      cur_state_q  <= cur_state_d;
      run_cnt_q    <= run_cnt_d;
      run_active_q <= run_active_d;
      overflow_q   <= overflow_d;
    end
  end

  rle_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (close_run),
    .push_data ({cur_state_q, run_cnt_q}),
    .pop_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (head_rec),
    .level     (level),
    .drop      (drop)
  );

  assign out_state = head_rec[REC_W-1:CNT_W];
  assign out_count = head_rec[CNT_W-1:0];
  assign overflow  = overflow_q;

endmodule

// File: doc/state_rle_logger.md
# state_rle_logger

Downstream observer for the 3-bit state output of the control FSM. It samples the state stream every clock and compresses consecutive identical states into run-length records (state, count). Records are buffered in a small FIFO and drained through a valid/ready port by a trace consumer such as a debug UART or the testbench. Overflow is flagged, never silent.

## Interface
- CNT_W, 5: run-count width; maximum run length is 2^CNT_W-1.
- DEPTH, 4: FIFO entries; must be a power of two, at least 2.
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- s_in  in  3  FSM state, sampled every posedge clk
- flush  in  1  close the current run now
- clear_ovf  in  1  synchronous clear of the overflow flag
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts the record
- out_state  out  3  state of the record at the FIFO head
- out_count  out  CNT_W  run length of the record at the FIFO head, 1..2^CNT_W-1
- overflow  out  1  sticky; set when a record was dropped
- level  out  log2(DEPTH)+1  FIFO occupancy

## Operation
- Run registers: cur_state, run_cnt, run_active.
- Reset values:
  - run_active=0, run_cnt=0, cur_state=0.
  - FIFO empty and pointers zero, so out_valid=0, out_state=0, out_count=0, level=0, overflow=0.
- Each posedge, with reset high:
  - If run_active=0: cur_state<=s_in, run_cnt<=1, run_active<=1. No push.
  - Else, if s_in!=cur_state, run_cnt==MAX, or flush: push {cur_state, run_cnt}, then cur_state<=s_in and run_cnt<=1.
  - Otherwise: run_cnt<=run_cnt+1.
- Saturation:
  - A run longer than MAX is split into records (s, MAX), (s, MAX)… followed by the remainder.
  - The cycle in which the MAX record is pushed counts as cycle 1 of the next run.
- FIFO:
  - A pop occurs when out_valid & out_ready.
  - A push is accepted if level<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the record is dropped and overflow<=1. FIFO contents are unchanged.
- Overflow: clear_ovf clears it. If a drop and clear_ovf happen in the same cycle, the drop wins and overflow stays 1.
- Order: records leave in push order; pointers wrap modulo DEPTH.
- Push and pop together: level is unchanged, also when level=DEPTH or level=1.
- Pop when empty: impossible, because out_valid=0.

## Timing
- The run closed at edge N appears on out_valid after edge N when the FIFO was empty: one cycle of latency, with no fall-through.
- out_state, out_count and out_valid come directly from FIFO registers and the head pointer. No combinational path from s_in or out_ready to any output.
- out_valid stays high and the head record stays stable until it is popped.
- Reset mid-run: the open run and all queued records are discarded; there is no partial record.
- flush with run_active=0 has no effect. flush together with a state change pushes exactly one record.

## Structure
- Package state_mon_pkg holds:
  - STATE_W=3
  - the default CNT_W
  - typedef rle_rec_t {state[2:0], count[CNT_W-1:0]}
- Sub-module rle_fifo (parameters WIDTH, DEPTH) contains:
  - the register array
  - the pointers
  - the level counter
  - push-accept/drop logic, which outputs a drop pulse
- The top level contains the run tracker, the overflow flag, and the rle_fifo instance.

## Test plan
- Reset, out_ready=1, s_in=0 for 3 cycles, then 3 for 2 cycles, then 5 held -> records (0,3), (3,2). level returns to 0.
- s_in=6 for 40 cycles, then 1 -> records (6,31), (6,9). No record has count 0.
- out_ready=0, s_in alternating 2/4 every cycle for 8 cycles -> level=4, overflow=1. Draining yields the first four records (2,1),(4,1),(2,1),(4,1). clear_ovf then drops overflow to 0.
- FIFO full (level=4), out_ready=1 in the same cycle as a state change -> new record is accepted, overflow stays 0, level stays 4.
- s_in=7 held for 4 cycles, pulse flush, hold 2 more, change to 0 -> records (7,4), (7,2).
- Assert reset low mid-run with 3 queued records -> level=0, out_valid=0, overflow=0 immediately. After release, the first record starts a new run.
